// File: rtl/anc_sequencer.sv
// rtl/anc_sequencer.sv - per-sample scheduler for the lowpass -> NLMS -> FIR anti-noise chain
// Issues one start pulse per stage, waits for its done, and tracks overruns and hung stages.
module anc_sequencer #(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int OVR_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sample_pulse_in,
  input  logic             nc_on_in,
  input  logic             adapt_en_in,
  input  logic             lp_amb_done_in,
  input  logic             lp_fb_done_in,
  input  logic             lms_done_in,
  input  logic             fir_done_in,
  input  logic             clr_status_in,
  output logic             lp_start_out,
  output logic             lms_start_out,
  output logic             fir_start_out,
  output logic             frame_done_out,
  output logic             busy_out,
  output logic [2:0]       state_out,
  output logic [OVR_W-1:0] overrun_count_out,
  output logic             timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LP   = 3'd1,
    S_LMS  = 3'd2,
    S_FIR  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             amb_q, amb_d;
  logic             fb_q, fb_d;
  logic             lp_start_q, lp_start_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             timeout_q, timeout_d;
  logic             lms_start, fir_start;
  logic             ovr_evt, tmo_evt, expired, lp_both;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    amb_d      = 1'b0;
    fb_d       = 1'b0;
    lp_start_d = 1'b0;
    lms_start  = 1'b0;
    fir_start  = 1'b0;
    tmo_evt    = 1'b0;
    expired    = (timer_q == TIMER_LAST);
    lp_both    = (amb_q | lp_amb_done_in) & (fb_q | lp_fb_done_in);

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (sample_pulse_in && nc_on_in) begin
          lp_start_d = 1'b1;
          state_d    = S_LP;
        end
      end
      S_LP: begin
        // Either lowpass may finish first; hold each done until both are seen.
        amb_d = amb_q | lp_amb_done_in;
        fb_d  = fb_q | lp_fb_done_in;
        if (lp_both) begin
          amb_d   = 1'b0;
          fb_d    = 1'b0;
          timer_d = '0;
          if (adapt_en_in) begin
            lms_start = 1'b1;
            state_d   = S_LMS;
          end else begin
            fir_start = 1'b1;
            state_d   = S_FIR;
          end
        end else if (expired) begin
          amb_d   = 1'b0;
          fb_d    = 1'b0;
          tmo_evt = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LMS: begin
        if (lms_done_in) begin
          fir_start = 1'b1;
          timer_d   = '0;
          state_d   = S_FIR;
        end else if (expired) begin
          tmo_evt = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FIR: begin
        if (fir_done_in) begin
          timer_d = '0;
          state_d = S_DONE;
        end else if (expired) begin
          tmo_evt = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    // A strobe while busy is dropped and counted; a same-cycle event beats clear.
    ovr_evt = sample_pulse_in && (state_q != S_IDLE);
    if (clr_status_in) begin
      ovr_d = ovr_evt ? OVR_W'(1) : '0;
    end else if (ovr_evt && !(&ovr_q)) begin
      ovr_d = ovr_q + 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
    timeout_d = tmo_evt | (timeout_q & ~clr_status_in);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      amb_q      <= 1'b0;
      fb_q       <= 1'b0;
      lp_start_q <= 1'b0;
      ovr_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      amb_q      <= amb_d;
      fb_q       <= fb_d;
      lp_start_q <= lp_start_d;
      ovr_q      <= ovr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign lp_start_out      = lp_start_q;
  assign lms_start_out     = lms_start;
  assign fir_start_out     = fir_start;
  assign frame_done_out    = (state_q == S_DONE);
  assign busy_out          = (state_q != S_IDLE);
  assign state_out         = state_q;
  assign overrun_count_out = ovr_q;
  assign timeout_out       = timeout_q;

endmodule

// File: tb/tb_anc_sequencer.sv
// tb/tb_anc_sequencer.sv - scoreboard bench for anc_sequencer
// Stimulus queues expected output pulses; a negedge monitor pops and compares them.
module tb_anc_sequencer;

  localparam int OVR_W = 8;
  localparam int K_LP  = 1;
  localparam int K_LMS = 2;
  localparam int K_FIR = 4;
  localparam int K_FD  = 8;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             sample_pulse_in = 1'b0;
  logic             nc_on_in = 1'b1;
  logic             adapt_en_in = 1'b1;
  logic             lp_amb_done_in = 1'b0;
  logic             lp_fb_done_in = 1'b0;
  logic             lms_done_in = 1'b0;
  logic             fir_done_in = 1'b0;
  logic             clr_status_in = 1'b0;
  logic             lp_start_out, lms_start_out, fir_start_out, frame_done_out;
  logic             busy_out, timeout_out;
  logic [2:0]       state_out;
  logic [OVR_W-1:0] overrun_count_out;

  anc_sequencer #(.TIMEOUT_CYCLES(2048), .OVR_W(OVR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_pulse_in(sample_pulse_in),
    .nc_on_in(nc_on_in), .adapt_en_in(adapt_en_in),
    .lp_amb_done_in(lp_amb_done_in), .lp_fb_done_in(lp_fb_done_in),
    .lms_done_in(lms_done_in), .fir_done_in(fir_done_in),
    .clr_status_in(clr_status_in), .lp_start_out(lp_start_out),
    .lms_start_out(lms_start_out), .fir_start_out(fir_start_out),
    .frame_done_out(frame_done_out), .busy_out(busy_out), .state_out(state_out),
    .overrun_count_out(overrun_count_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_q.push_back('{kind, at});
  endtask

  // Drop every strobe input each cycle so a pulse set after run_until lasts one cycle.
  task automatic run_until(input int t);
    while (cyc < t) begin
      @(posedge clk_in);
      #1;
      sample_pulse_in = 1'b0;
      lp_amb_done_in  = 1'b0;
      lp_fb_done_in   = 1'b0;
      lms_done_in     = 1'b0;
      fir_done_in     = 1'b0;
      clr_status_in   = 1'b0;
    end
  endtask

  wire [3:0] act_pulses = {frame_done_out, fir_start_out, lms_start_out, lp_start_out};

  always @(negedge clk_in) begin
    if (act_pulses != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(act_pulses), 0);
      end else begin
        check("pulse_kind", int'(act_pulses), exp_q[0].kind);
        check("pulse_cycle", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b;

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_ovr", int'(overrun_count_out), 0);
    check("rst_timeout", int'(timeout_out), 0);
    check("rst_pulses", int'(act_pulses), 0);
    rst_in = 1'b1;
    run_until(cyc + 2);

    // Bypass: no frame starts
    b = cyc;
    nc_on_in = 1'b0;
    sample_pulse_in = 1'b1;
    run_until(b + 3);
    check("bypass_state", int'(state_out), 0);
    nc_on_in = 1'b1;

    // Normal frame
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 40); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 40);
    run_until(b + 200); check("normal_in_lms", int'(state_out), 2);
    check("normal_busy", int'(busy_out), 1);
    nc_on_in = 1'b0;
    run_until(b + 300); lms_done_in = 1'b1; expect_ev(K_FIR, b + 300);
    run_until(b + 380); fir_done_in = 1'b1; expect_ev(K_FD, b + 381);
    run_until(b + 385);
    nc_on_in = 1'b1;
    check("normal_ovr", int'(overrun_count_out), 0);
    check("normal_idle", int'(state_out), 0);
    check("normal_drained", exp_q.size(), 0);

    // Skewed lowpass dones with a stray NLMS done in between
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 40); lp_amb_done_in = 1'b1;
    run_until(b + 45); lms_done_in = 1'b1;
    run_until(b + 46); check("skew_still_lp", int'(state_out), 1);
    run_until(b + 55); lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 55);
    run_until(b + 100); lms_done_in = 1'b1; expect_ev(K_FIR, b + 100);
    run_until(b + 150); fir_done_in = 1'b1; expect_ev(K_FD, b + 151);
    run_until(b + 155);
    check("skew_drained", exp_q.size(), 0);

    // Frozen adaptation skips the NLMS stage
    b = cyc;
    adapt_en_in = 1'b0;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 30); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_FIR, b + 30);
    run_until(b + 31); check("freeze_in_fir", int'(state_out), 3);
    run_until(b + 45); lms_done_in = 1'b1;
    run_until(b + 60); fir_done_in = 1'b1; expect_ev(K_FD, b + 61);
    run_until(b + 65);
    adapt_en_in = 1'b1;
    check("freeze_drained", exp_q.size(), 0);

    // Overrun during LMS and during DONE
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 10); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 10);
    run_until(b + 20); sample_pulse_in = 1'b1;
    run_until(b + 21); check("ovr_one", int'(overrun_count_out), 1);
    run_until(b + 30); lms_done_in = 1'b1; expect_ev(K_FIR, b + 30);
    run_until(b + 40); fir_done_in = 1'b1; expect_ev(K_FD, b + 41);
    run_until(b + 41); sample_pulse_in = 1'b1;
    run_until(b + 42); check("ovr_in_done", int'(overrun_count_out), 2);
    check("ovr_done_no_start", int'(state_out), 0);

    // Clear racing an overrun, then saturation
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 10); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 10);
    run_until(b + 15); clr_status_in = 1'b1; sample_pulse_in = 1'b1;
    run_until(b + 16); check("clr_vs_ovr", int'(overrun_count_out), 1);
    for (int i = 0; i < 300; i++) begin
      run_until(b + 20 + i);
      sample_pulse_in = 1'b1;
    end
    run_until(b + 320); check("ovr_saturate", int'(overrun_count_out), 255);
    run_until(b + 330); lms_done_in = 1'b1; expect_ev(K_FIR, b + 330);
    run_until(b + 340); fir_done_in = 1'b1; expect_ev(K_FD, b + 341);
    run_until(b + 350); clr_status_in = 1'b1;
    run_until(b + 351); check("ovr_cleared", int'(overrun_count_out), 0);

    // Hung NLMS stage
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 10); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 10);
    run_until(b + 2058);
    check("tmo_last_wait", int'(state_out), 2);
    check("tmo_not_yet", int'(timeout_out), 0);
    run_until(b + 2059);
    check("tmo_idle", int'(state_out), 0);
    check("tmo_flag", int'(timeout_out), 1);
    run_until(b + 2070); sample_pulse_in = 1'b1; expect_ev(K_LP, b + 2071);
    run_until(b + 2072); check("tmo_sticky", int'(timeout_out), 1);
    run_until(b + 2075); clr_status_in = 1'b1;
    run_until(b + 2076); check("tmo_cleared", int'(timeout_out), 0);
    run_until(b + 2080); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 2080);
    run_until(b + 2090); lms_done_in = 1'b1; expect_ev(K_FIR, b + 2090);
    run_until(b + 2100); fir_done_in = 1'b1; expect_ev(K_FD, b + 2101);
    run_until(b + 2105);
    check("tmo_drained", exp_q.size(), 0);

    // Asynchronous reset in FIR
    b = cyc;
    sample_pulse_in = 1'b1; expect_ev(K_LP, b + 1);
    run_until(b + 10); lp_amb_done_in = 1'b1; lp_fb_done_in = 1'b1; expect_ev(K_LMS, b + 10);
    run_until(b + 15); sample_pulse_in = 1'b1;
    run_until(b + 20); lms_done_in = 1'b1; expect_ev(K_FIR, b + 20);
    run_until(b + 25);
    check("pre_rst_ovr", int'(overrun_count_out), 1);
    check("pre_rst_fir", int'(state_out), 3);
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_state", int'(state_out), 0);
    check("async_rst_busy", int'(busy_out), 0);
    check("async_rst_ovr", int'(overrun_count_out), 0);
    check("async_rst_pulses", int'(act_pulses), 0);
    run_until(b + 28); rst_in = 1'b1;
    run_until(b + 30); fir_done_in = 1'b1;
    run_until(b + 34);
    check("late_done_idle", int'(state_out), 0);
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
